rr_mux_arbiter: RTL
===================

// Module: rr_mux_arbiter
// PURPOSE
//   Round-robin arbiter that shares one N:1 data mux between N requesters.
//   It picks one requester per transfer, steers that requester's data through the mux
//   and captures it in a single-entry output register with valid/ready handshake.
//   Sits between several producers and one shared consumer. Fairness is rotating-priority.
// PARAMETERS
//   N      4   number of requesters (>=2)
//   W      8   data width per requester
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      asynchronous reset, active-high
//   req        in   N      req[i]=1: requester i offers in_data[i]
//   in_data    in   N*W    requester i data at bits [i*W +: W]
//   ack        out  N      one-hot; ack[i]=1: requester i's data taken this cycle
//   out_valid  out  1      output register holds a word
//   out_ready  in   1      consumer accepts word when out_valid && out_ready
//   out_data   out  W      registered muxed data
//   out_src    out  $clog2(N)  index of requester that supplied out_data
// BEHAVIOUR
//   Reset (async, rst=1): out_valid=0, out_data=0, out_src=0, last=N-1, state EMPTY.
//     ack is 0 throughout reset.
//   States: EMPTY (out_valid=0), FULL (out_valid=1).
//   can_load = (state==EMPTY) | (out_ready & out_valid). Combinational, same cycle.
//   Winner = first i with req[i]=1, scanning last+1, last+2, ... mod N (wraps).
//   ack[winner]=1 iff can_load & |req. ack is combinational from req/state/last/out_ready.
//     At most one ack bit is high. No ack while FULL and out_ready=0.
//   On an edge with an ack:
//     - out_data <= in_data[winner]; out_src <= winner; last <= winner; state FULL.
//   On an edge where the consumer accepts and no req is pending: state EMPTY, out_valid=0.
//     out_data/out_src keep their old values.
//   Latency: req asserted in EMPTY -> ack same cycle -> out_valid next cycle.
//   Throughput: 1 word/cycle while out_ready=1 and any req is high.
//   Back-pressure: while FULL & !out_ready, out_data/out_src/out_valid are stable.
//     Requesters hold req and data until they see ack.
//   Simultaneous drain + load: the new word replaces the old one in the same edge, no bubble.
//   Pointer: last changes only on ack. A request that drops before ack does not move priority.
//   Requester i that keeps req high after its ack gets lowest priority next round.
//     If it is the only requester, it wins again.
//   Reset mid-operation: the held word is discarded and out_valid drops immediately (async).
//     Priority restarts at requester 0.
//   req bits with no matching data are ignored.
//     Data is sampled only from the winner; other in_data slices are don't-care.
// CONFIGURATION
//   RR_MUX_ARBITER_STATS_EN
//     defined: adds output port grant_cnt [N*16], 16-bit wrapping counter per requester.
//       Counter i increments on each ack[i]. Reset to 0 by rst.
//     undefined: port absent, counters not built. All other behaviour is identical.
// TESTING
//   1 Reset: rst=1 with req=4'b1111 -> ack=0, out_valid=0, out_data=0, out_src=0.
//     After release: first ack=4'b0001.
//   2 All request, out_ready=1, in_data[i]=8'hA0+i -> ack sequence 0001,0010,0100,1000,0001.
//     out_data = A0,A1,A2,A3,A0 one cycle later, out_src=0,1,2,3,0. No bubbles.
//   3 Back-pressure: FULL with out_data=A1, out_ready=0 for 5 cycles -> ack=0.
//     out_data=A1 and out_valid=1 stable. out_ready=1 -> word drains, ack to next requester same cycle.
//   4 Wrap/skip: last=2, req=4'b0011 -> ack=4'b0001.
//     Then req=4'b0010 only -> ack=4'b0010. Sole requester 3 held high -> wins every cycle.
//   5 Drain to empty: single word, req=0, out_ready=1 -> out_valid=0 next cycle, out_data unchanged.
//   6 Reset mid-stream while FULL -> out_valid falls without a clock edge.
//     STATS_EN build: grant_cnt all 0 after reset; after test 2 (5 grants) counters = 2,1,1,1.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// rr_mux_arbiter : rotating-priority arbiter steering N requesters through one
//                  N:1 mux into a single-entry valid/ready output register.
// Option macro   : RR_MUX_ARBITER_STATS_EN (per-requester grant counters)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module rr_mux_arbiter #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N-1:0]                 req,
   input  logic [N*W-1:0]               in_data,
   output logic [N-1:0]                 ack,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [W-1:0]                 out_data,
   output logic [$clog2(N)-1:0]         out_src
`ifdef RR_MUX_ARBITER_STATS_EN
   ,
   output logic [N*16-1:0]              grant_cnt
`endif
);

   localparam int SW = $clog2(N);

   typedef enum logic [0:0] {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t          r_state;
   logic [SW-1:0]   r_last;
   logic [W-1:0]    r_data;
   logic [SW-1:0]   r_src;

   logic            w_can_load;
   logic            w_found;
   logic [SW-1:0]   w_win;
   logic [W-1:0]    w_win_data;
   logic [N-1:0]    w_ack;

   assign w_can_load = (r_state == S_EMPTY) | (out_ready & (r_state == S_FULL));

   // Scan last+1, last+2, ... (mod N); the first requester found wins.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 1; k <= N; k++) begin
         if (!w_found && req[SW'((int'(r_last) + k) % N)]) begin
            w_found = 1'b1;
            w_win   = SW'((int'(r_last) + k) % N);
         end
      end
   end

   always_comb begin
      w_win_data = '0;
      for (int i = 0; i < N; i++) begin
         if (w_win == SW'(i)) begin
            w_win_data = in_data[i*W +: W];
         end
      end
   end

   // rst gates ack directly so no grant is visible while reset is held.
   always_comb begin
      w_ack = '0;
      if (w_found && w_can_load && !rst) begin
         w_ack[w_win] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_EMPTY;
         r_last  <= SW'(N - 1);
         r_data  <= '0;
         r_src   <= '0;
      end else if (|w_ack) begin
         r_state <= S_FULL;
         r_last  <= w_win;
         r_data  <= w_win_data;
         r_src   <= w_win;
      end else if (out_ready && r_state == S_FULL) begin
         r_state <= S_EMPTY;
      end
   end

   assign ack       = w_ack;
   assign out_valid = (r_state == S_FULL);
   assign out_data  = r_data;
   assign out_src   = r_src;

`ifdef RR_MUX_ARBITER_STATS_EN
   logic [15:0] r_cnt [N];

   for (genvar g = 0; g < N; g++) begin : g_stats
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_cnt[g] <= '0;
         end else if (w_ack[g]) begin
            r_cnt[g] <= r_cnt[g] + 16'd1;
         end
      end
      assign grant_cnt[g*16 +: 16] = r_cnt[g];
   end
`endif

endmodule

`default_nettype wire
